// File: rtl/rs_station_if.sv
// Reservation station bundle: decoder dispatch, CDB snoop and ALU issue signals.
// No storage; pure signal grouping shared by the station and its neighbours.
// master = upstream/ALU side driving dispatch and CDB, slave = the station itself.
interface rs_station_if #(
  parameter int RS_DEPTH = 8,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 9,
  parameter int CDB_N    = 2
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic                   rs_full;
  logic [IDX_W:0]         rs_count;

  logic                   dec_valid;
  logic [OP_W-1:0]        dec_op;
  logic [31:0]            dec_vj;
  logic [31:0]            dec_vk;
  logic                   dec_has_qj;
  logic                   dec_has_qk;
  logic [ROB_W-1:0]       dec_qj;
  logic [ROB_W-1:0]       dec_qk;
  logic [31:0]            dec_imm;
  logic [ROB_W-1:0]       dec_rob_id;

  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*ROB_W-1:0] cdb_rob_id;
  logic [CDB_N*32-1:0]    cdb_value;

  logic                   iss_valid;
  logic                   iss_ready;
  logic [OP_W-1:0]        iss_op;
  logic [31:0]            iss_vj;
  logic [31:0]            iss_vk;
  logic [31:0]            iss_imm;
  logic [ROB_W-1:0]       iss_rob_id;

  modport master (
    input  rs_full, rs_count,
    output dec_valid, dec_op, dec_vj, dec_vk, dec_has_qj, dec_has_qk,
           dec_qj, dec_qk, dec_imm, dec_rob_id,
    output cdb_valid, cdb_rob_id, cdb_value,
    input  iss_valid, iss_op, iss_vj, iss_vk, iss_imm, iss_rob_id,
    output iss_ready
  );

  modport slave (
    output rs_full, rs_count,
    input  dec_valid, dec_op, dec_vj, dec_vk, dec_has_qj, dec_has_qk,
           dec_qj, dec_qk, dec_imm, dec_rob_id,
    input  cdb_valid, cdb_rob_id, cdb_value,
    output iss_valid, iss_op, iss_vj, iss_vk, iss_imm, iss_rob_id,
    input  iss_ready
  );
endinterface

// File: rtl/rs_station.sv
// Reservation station: holds RS_DEPTH ALU ops, snoops CDB_N broadcast channels, issues lowest ready index.
// Latency: dispatch-to-issue 2 cycles; wakeup-to-issue 2 cycles, 1 with RS_WAKEUP_BYPASS_EN defined.
// Backpressure: issue register holds while iss_valid && !iss_ready; dispatch refused while rs_full.
module rs_station #(
  parameter int RS_DEPTH = 8,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 9,
  parameter int CDB_N    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  rs_station_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(RS_DEPTH);
  localparam logic [IDX_W:0] ONE_CNT  = {{IDX_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } snoop_t;

  // Entry storage
  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] has_qj, has_qk;
  logic [OP_W-1:0]     op       [RS_DEPTH];
  logic [31:0]         vj       [RS_DEPTH];
  logic [31:0]         vk       [RS_DEPTH];
  logic [31:0]         imm      [RS_DEPTH];
  logic [ROB_W-1:0]    qj       [RS_DEPTH];
  logic [ROB_W-1:0]    qk       [RS_DEPTH];
  logic [ROB_W-1:0]    rob_dest [RS_DEPTH];

  // Post-wakeup view of every entry
  snoop_t              snp_j [RS_DEPTH];
  snoop_t              snp_k [RS_DEPTH];
  logic [RS_DEPTH-1:0] wk_hj, wk_hk, rdy_vec;
  logic [31:0]         wk_vj [RS_DEPTH];
  logic [31:0]         wk_vk [RS_DEPTH];

  snoop_t              snp_dj, snp_dk;
  logic [IDX_W-1:0]    sel_idx, free_idx;
  logic                sel_any, sel_fire, disp_fire;
  logic [IDX_W:0]      count_q;
  logic                iss_valid_q;
  logic [OP_W-1:0]     iss_op_q;
  logic [31:0]         iss_vj_q, iss_vk_q, iss_imm_q;
  logic [ROB_W-1:0]    iss_rob_q;

  // Parallel tag compare across all channels; lowest channel index wins on multiple hits.
  function automatic snoop_t snoop(input logic [ROB_W-1:0]       tag,
                                   input logic [CDB_N-1:0]       v,
                                   input logic [CDB_N*ROB_W-1:0] ids,
                                   input logic [CDB_N*32-1:0]    vals);
    snoop_t s;
    s = '0;
    for (int c = CDB_N-1; c >= 0; c--) begin
      if (v[c] && ids[c*ROB_W +: ROB_W] == tag) begin
        s.hit = 1'b1;
        s.val = vals[c*32 +: 32];
      end
    end
    return s;
  endfunction

  // Wake pending operands from the CDB and derive per-entry readiness.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      snp_j[i] = snoop(qj[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      snp_k[i] = snoop(qk[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      wk_hj[i] = has_qj[i] & ~snp_j[i].hit;
      wk_hk[i] = has_qk[i] & ~snp_k[i].hit;
      wk_vj[i] = (has_qj[i] && snp_j[i].hit) ? snp_j[i].val : vj[i];
      wk_vk[i] = (has_qk[i] && snp_k[i].hit) ? snp_k[i].val : vk[i];
`ifdef RS_WAKEUP_BYPASS_EN
      rdy_vec[i] = busy[i] & ~wk_hj[i] & ~wk_hk[i];
`else
      rdy_vec[i] = busy[i] & ~has_qj[i] & ~has_qk[i];
`endif
    end
  end

  // Same-cycle capture of a broadcast for the op being dispatched.
  always_comb begin
    snp_dj = snoop(bus.dec_qj, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    snp_dk = snoop(bus.dec_qk, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
  end

  // Lowest-index ready entry for issue, lowest-index free entry for allocation.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign sel_fire  = rdy_in && !clear && sel_any && (!iss_valid_q || bus.iss_ready);
  assign disp_fire = rdy_in && !clear && bus.dec_valid && (count_q != FULL_CNT);

  // Operand payload: wakeup updates plus the newly dispatched op; frozen while paused.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        has_qj[i] <= wk_hj[i];
        has_qk[i] <= wk_hk[i];
        vj[i]     <= wk_vj[i];
        vk[i]     <= wk_vk[i];
      end
      if (disp_fire) begin
        op[free_idx]       <= bus.dec_op;
        imm[free_idx]      <= bus.dec_imm;
        rob_dest[free_idx] <= bus.dec_rob_id;
        qj[free_idx]       <= bus.dec_qj;
        qk[free_idx]       <= bus.dec_qk;
        has_qj[free_idx]   <= bus.dec_has_qj & ~snp_dj.hit;
        has_qk[free_idx]   <= bus.dec_has_qk & ~snp_dk.hit;
        vj[free_idx]       <= (bus.dec_has_qj && snp_dj.hit) ? snp_dj.val : bus.dec_vj;
        vk[free_idx]       <= (bus.dec_has_qk && snp_dk.hit) ? snp_dk.val : bus.dec_vk;
      end
    end
  end

  // Occupancy, issue register and count; clear flushes ahead of everything else.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_imm_q   <= '0;
      iss_rob_q   <= '0;
    end else if (clear) begin
      busy        <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
    end else if (rdy_in) begin
      if (sel_fire) begin
        busy[sel_idx] <= 1'b0;
        iss_valid_q   <= 1'b1;
        iss_op_q      <= op[sel_idx];
        iss_vj_q      <= wk_vj[sel_idx];
        iss_vk_q      <= wk_vk[sel_idx];
        iss_imm_q     <= imm[sel_idx];
        iss_rob_q     <= rob_dest[sel_idx];
      end else if (bus.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
      // Allocation uses pre-edge busy, so it never lands on the entry being issued.
      if (disp_fire) busy[free_idx] <= 1'b1;
      case ({disp_fire, sel_fire})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.rs_count   = count_q;
  assign bus.rs_full    = (count_q == FULL_CNT);
  assign bus.iss_valid  = iss_valid_q;
  assign bus.iss_op     = iss_op_q;
  assign bus.iss_vj     = iss_vj_q;
  assign bus.iss_vk     = iss_vk_q;
  assign bus.iss_imm    = iss_imm_q;
  assign bus.iss_rob_id = iss_rob_q;
endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus randomized traffic against a slot-level reference model.
// Model updates on each rising edge; a monitor compares DUT outputs on the falling edge.
// Expected issues are queued by the model and popped by the monitor on each accepted handshake.
module tb_rs_station;
  localparam int RS_DEPTH = 8;
  localparam int ROB_W    = 4;
  localparam int OP_W     = 9;
  localparam int CDB_N    = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear  = 1'b0;

  always #5 clk_in = ~clk_in;

  rs_station_if #(.RS_DEPTH(RS_DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) bus ();

  rs_station #(.RS_DEPTH(RS_DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob;
  } iss_t;

  iss_t exp_q[$];
  int   issued_log[$];

  // Reference model: a slot table with occupancy flags and an issue slot.
  bit               m_busy [RS_DEPTH];
  bit               m_hj   [RS_DEPTH];
  bit               m_hk   [RS_DEPTH];
  logic [31:0]      m_vj   [RS_DEPTH];
  logic [31:0]      m_vk   [RS_DEPTH];
  logic [31:0]      m_imm  [RS_DEPTH];
  logic [OP_W-1:0]  m_op   [RS_DEPTH];
  logic [ROB_W-1:0] m_qj   [RS_DEPTH];
  logic [ROB_W-1:0] m_qk   [RS_DEPTH];
  logic [ROB_W-1:0] m_rob  [RS_DEPTH];
  int               m_cnt;
  bit               m_iv;
  bit               m_accept;

  function automatic bit cdb_lookup(input logic [ROB_W-1:0] tag, output logic [31:0] val);
    val = '0;
    for (int c = 0; c < CDB_N; c++) begin
      if (bus.cdb_valid[c] && bus.cdb_rob_id[c*ROB_W +: ROB_W] == tag) begin
        val = bus.cdb_value[c*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit          wj [RS_DEPTH];
    bit          wk [RS_DEPTH];
    logic [31:0] nvj [RS_DEPTH];
    logic [31:0] nvk [RS_DEPTH];
    logic [31:0] v;
    int          sel;
    int          free;
    int          cnt_pre;
    bit          rdy;
    m_accept = 1'b0;
    if (clear) begin
      for (int i = 0; i < RS_DEPTH; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
      m_iv  = 1'b0;
      exp_q.delete();
      return;
    end
    if (!rdy_in) return;
    cnt_pre = m_cnt;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wj[i] = m_hj[i]; nvj[i] = m_vj[i];
      wk[i] = m_hk[i]; nvk[i] = m_vk[i];
      if (m_hj[i] && cdb_lookup(m_qj[i], v)) begin wj[i] = 1'b0; nvj[i] = v; end
      if (m_hk[i] && cdb_lookup(m_qk[i], v)) begin wk[i] = 1'b0; nvk[i] = v; end
    end
    sel = -1;
    if (!m_iv || bus.iss_ready) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
        rdy = m_busy[i] && !wj[i] && !wk[i];
`else
        rdy = m_busy[i] && !m_hj[i] && !m_hk[i];
`endif
        if (sel < 0 && rdy) sel = i;
      end
    end
    free = -1;
    for (int i = 0; i < RS_DEPTH; i++) if (free < 0 && !m_busy[i]) free = i;
    if (m_iv && bus.iss_ready) m_iv = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      m_hj[i] = wj[i]; m_vj[i] = nvj[i];
      m_hk[i] = wk[i]; m_vk[i] = nvk[i];
    end
    if (sel >= 0) begin
      exp_q.push_back('{m_op[sel], nvj[sel], nvk[sel], m_imm[sel], m_rob[sel]});
      m_busy[sel] = 1'b0;
      m_iv = 1'b1;
      m_cnt--;
    end
    if (bus.dec_valid && cnt_pre < RS_DEPTH && free >= 0) begin
      m_busy[free] = 1'b1;
      m_op[free]   = bus.dec_op;
      m_imm[free]  = bus.dec_imm;
      m_rob[free]  = bus.dec_rob_id;
      m_qj[free]   = bus.dec_qj;
      m_qk[free]   = bus.dec_qk;
      m_hj[free]   = bus.dec_has_qj;
      m_hk[free]   = bus.dec_has_qk;
      m_vj[free]   = bus.dec_vj;
      m_vk[free]   = bus.dec_vk;
      if (bus.dec_has_qj && cdb_lookup(bus.dec_qj, v)) begin m_hj[free] = 1'b0; m_vj[free] = v; end
      if (bus.dec_has_qk && cdb_lookup(bus.dec_qk, v)) begin m_hk[free] = 1'b0; m_vk[free] = v; end
      m_cnt++;
      m_accept = 1'b1;
    end
  endtask

  // Model advances on every rising edge.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_DEPTH; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
      m_iv = 1'b0;
      m_accept = 1'b0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compare occupancy and issue register, pop on accepted handshakes.
  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("rs_count", 32'(bus.rs_count), 32'(m_cnt));
      chk("rs_full", 32'(bus.rs_full), 32'(m_cnt == RS_DEPTH));
      chk("iss_valid", 32'(bus.iss_valid), 32'(m_iv));
      if (bus.iss_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL iss_unexpected: got iss_valid=1 want no pending issue at %0t", $time);
        end else begin
          chk("iss_op", 32'(bus.iss_op), 32'(exp_q[0].op));
          chk("iss_vj", bus.iss_vj, exp_q[0].vj);
          chk("iss_vk", bus.iss_vk, exp_q[0].vk);
          chk("iss_imm", bus.iss_imm, exp_q[0].imm);
          chk("iss_rob_id", 32'(bus.iss_rob_id), 32'(exp_q[0].rob));
          if (bus.iss_ready && rdy_in && !clear) begin
            issued_log.push_back(int'(exp_q[0].rob));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_dec(input int op, input logic [31:0] vj, input logic [31:0] vk,
                         input bit hj, input int qj, input bit hk, input int qk,
                         input logic [31:0] imm, input int rob);
    bus.dec_valid  = 1'b1;
    bus.dec_op     = OP_W'(op);
    bus.dec_vj     = vj;
    bus.dec_vk     = vk;
    bus.dec_has_qj = hj;
    bus.dec_qj     = ROB_W'(qj);
    bus.dec_has_qk = hk;
    bus.dec_qk     = ROB_W'(qk);
    bus.dec_imm    = imm;
    bus.dec_rob_id = ROB_W'(rob);
  endtask

  task automatic set_cdb(input int c, input int tag, input logic [31:0] val);
    bus.cdb_valid[c]                 = 1'b1;
    bus.cdb_rob_id[c*ROB_W +: ROB_W] = ROB_W'(tag);
    bus.cdb_value[c*32 +: 32]        = val;
  endtask

  initial begin
    bus.dec_valid = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.dec_valid  = 1'b0;
    bus.cdb_valid  = '0;
    bus.cdb_rob_id = '0;
    bus.cdb_value  = '0;
    bus.iss_ready  = 1'b1;

    // Reset state
    cyc(); cyc();
    chk("rst_iss_valid", 32'(bus.iss_valid), 0);
    chk("rst_rs_count", 32'(bus.rs_count), 0);
    chk("rst_rs_full", 32'(bus.rs_full), 0);
    chk("rst_iss_op", 32'(bus.iss_op), 0);
    chk("rst_iss_vj", bus.iss_vj, 0);
    chk("rst_iss_rob", 32'(bus.iss_rob_id), 0);
    rst_in = 1'b1;
    cyc();

    // Both operands ready: issue two edges after dispatch
    set_dec(9'h033, 5, 7, 0, 0, 0, 0, 0, 3);
    cyc();
    bus.dec_valid = 1'b0;
    cyc();
    chk("t1_valid", 32'(bus.iss_valid), 1);
    chk("t1_op", 32'(bus.iss_op), 32'h033);
    chk("t1_vj", bus.iss_vj, 5);
    chk("t1_vk", bus.iss_vk, 7);
    chk("t1_rob", 32'(bus.iss_rob_id), 3);
    chk("t1_count", 32'(bus.rs_count), 0);
    cyc();
    chk("t1_drained", 32'(bus.iss_valid), 0);

    // Pending qj=6, broadcast on channel 1 three edges later
    set_dec(9'h013, 32'hdead, 32'h11, 1, 6, 0, 0, 32'h40, 4);
    cyc();
    bus.dec_valid = 1'b0;
    cyc(); cyc();
    set_cdb(1, 6, 32'h1234);
    cyc();
    bus.cdb_valid = '0;
`ifndef RS_WAKEUP_BYPASS_EN
    chk("t2_not_yet", 32'(bus.iss_valid), 0);
    cyc();
`endif
    chk("t2_valid", 32'(bus.iss_valid), 1);
    chk("t2_vj", bus.iss_vj, 32'h1234);
    cyc(); cyc();

    // Fill all entries with pending ops, 9th dispatch refused, then issue in index order
    issued_log.delete();
    bus.iss_ready = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      set_dec(9'h0a0 + i, i, 100 + i, 1, 12, 0, 0, i, i);
      cyc();
    end
    chk("t3_full", 32'(bus.rs_full), 1);
    set_dec(9'h1ff, 1, 2, 0, 0, 0, 0, 0, 15);
    cyc();
    bus.dec_valid = 1'b0;
    chk("t3_count_held", 32'(bus.rs_count), RS_DEPTH);
    set_cdb(0, 12, 32'h77);
    cyc();
    bus.cdb_valid = '0;
    bus.iss_ready = 1'b1;
    repeat (12) cyc();
    chk("t3_issued_n", 32'(issued_log.size()), RS_DEPTH);
    for (int i = 0; i < issued_log.size(); i++) chk("t3_order", 32'(issued_log[i]), 32'(i));
    chk("t3_empty", 32'(bus.rs_count), 0);

    // Dispatch-cycle capture of a channel-0 broadcast
    set_dec(9'h0b3, 0, 5, 1, 2, 0, 0, 0, 5);
    set_cdb(0, 2, 9);
    cyc();
    bus.dec_valid = 1'b0;
    bus.cdb_valid = '0;
    cyc();
    chk("t4_valid", 32'(bus.iss_valid), 1);
    chk("t4_vj", bus.iss_vj, 9);
    chk("t4_rob", 32'(bus.iss_rob_id), 5);
    cyc();

    // Clear with rdy_in low flushes 5 busy entries and a held issue
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_dec(9'h0c0 + i, i, i, 0, 0, 0, 0, 0, i);
      cyc();
    end
    bus.dec_valid = 1'b0;
    chk("t5_count", 32'(bus.rs_count), 5);
    chk("t5_held", 32'(bus.iss_valid), 1);
    clear  = 1'b1;
    rdy_in = 1'b0;
    cyc();
    clear  = 1'b0;
    rdy_in = 1'b1;
    chk("t5_count0", 32'(bus.rs_count), 0);
    chk("t5_iss0", 32'(bus.iss_valid), 0);
    chk("t5_full0", 32'(bus.rs_full), 0);
    bus.iss_ready = 1'b1;

    // Pause for 3 edges with dispatch and broadcast asserted
    rdy_in = 1'b0;
    set_dec(9'h0d0, 3, 4, 0, 0, 0, 0, 0, 7);
    set_cdb(0, 9, 1);
    repeat (3) cyc();
    chk("t6_paused_count", 32'(bus.rs_count), 0);
    chk("t6_paused_iss", 32'(bus.iss_valid), 0);
    rdy_in = 1'b1;
    cyc();
    bus.dec_valid = 1'b0;
    bus.cdb_valid = '0;
    chk("t6_resume_count", 32'(bus.rs_count), 1);
    cyc();
    chk("t6_issue", 32'(bus.iss_valid), 1);
    chk("t6_rob", 32'(bus.iss_rob_id), 7);
    cyc();

    // Randomized traffic; the decoder holds its request until the model reports acceptance
    repeat (3000) begin
      rdy_in        = ($urandom % 10) != 0;
      clear         = ($urandom % 60) == 0;
      bus.iss_ready = ($urandom % 4) != 0;
      bus.cdb_valid = '0;
      for (int c = 0; c < CDB_N; c++) begin
        if (($urandom % 3) == 0) set_cdb(c, 8 + ($urandom % 8), $urandom);
      end
      for (int c = 1; c < CDB_N; c++) begin
        if (bus.cdb_valid[c] && bus.cdb_valid[0] &&
            bus.cdb_rob_id[c*ROB_W +: ROB_W] == bus.cdb_rob_id[ROB_W-1:0])
          bus.cdb_value[c*32 +: 32] = bus.cdb_value[31:0];
      end
      if (m_accept || !bus.dec_valid) begin
        set_dec($urandom_range(0, 511), $urandom, $urandom,
                $urandom % 2, 8 + ($urandom % 8), $urandom % 2, 8 + ($urandom % 8),
                $urandom, $urandom_range(0, 15));
        bus.dec_valid = ($urandom % 2) != 0;
      end
      cyc();
    end

    // Drain: broadcast every external tag so all pending ops issue
    rdy_in        = 1'b1;
    clear         = 1'b0;
    bus.dec_valid = 1'b0;
    bus.iss_ready = 1'b1;
    for (int t = 8; t < 16; t++) begin
      bus.cdb_valid = '0;
      set_cdb(0, t, 32'(t * 3));
      cyc();
    end
    bus.cdb_valid = '0;
    repeat (20) cyc();
    chk("final_count", 32'(bus.rs_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
